// File: rtl/arm_mc_pkg.sv
// Shared definitions for the multicycle ARM core: address width, reset vector,
// fetch FSM state encoding and the canonical NOP word.
package arm_mc_pkg;

   localparam int unsigned ARM_ADDR_W   = 32;
   localparam logic [31:0] ARM_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] INSTR_NOP    = 32'hE1A0_0000;  // MOV r0, r0

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DONE  = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/fetch_prefetch_buf.sv
// One-entry speculative fetch buffer {valid, adr, data} holding the word after the
// last IR load. Compiled only when FETCH_PREFETCH_EN is defined.
`ifdef FETCH_PREFETCH_EN
module fetch_prefetch_buf
   import arm_mc_pkg::*;
#(
   parameter int unsigned ADDR_W = ARM_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_adr,
   input  logic [ADDR_W-1:0] pc,
   input  logic              pc_write,
   input  logic [ADDR_W-1:0] pc_next,
   input  logic              mem_ready,
   input  logic [ADDR_W-1:0] mem_rdata,
   output logic              busy,
   output logic              hit_c,
   output logic [ADDR_W-1:0] data
);

   logic              valid_q;
   logic              discard_q;
   logic [ADDR_W-1:0] adr_q;
   logic              inval;

   assign inval = pc_write && (pc_next != adr_q);
   assign hit_c = valid_q && (adr_q == pc);

   // A redirect away from the speculative address poisons the read still in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         busy      <= 1'b0;
         valid_q   <= 1'b0;
         discard_q <= 1'b0;
         adr_q     <= '0;
         data      <= '0;
      end else if (start) begin
         busy      <= 1'b1;
         valid_q   <= 1'b0;
         adr_q     <= start_adr;
         discard_q <= pc_write && (pc_next != start_adr);
      end else begin
         if (busy && mem_ready) begin
            busy    <= 1'b0;
            valid_q <= !discard_q && !inval;
            data    <= mem_rdata;
         end else if (inval) begin
            valid_q <= 1'b0;
         end
         if (inval) begin
            discard_q <= 1'b1;
         end
      end
   end

endmodule
`endif

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns PC and IR, runs req/ready with a variable-latency
// instruction memory. Define FETCH_PREFETCH_EN for the one-entry PC+4 prefetch buffer.
module fetch_unit
   import arm_mc_pkg::*;
#(
   parameter int unsigned       ADDR_W   = ARM_ADDR_W,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(ARM_RESET_PC)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              IRWrite,
   input  logic              PCWrite,
   input  logic [ADDR_W-1:0] pc_next,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_adr,
   input  logic              mem_ready,
   input  logic [ADDR_W-1:0] mem_rdata,
   output logic [ADDR_W-1:0] Instr,
   output logic [ADDR_W-1:0] PC,
   output logic              fetch_stall,
   output logic              fetch_done
);

   fetch_state_e      state_q;
   fetch_state_e      state_d;
   logic              demand_miss;
   logic              buf_hit;
   logic              pf_issue;
   logic              pf_busy;
   logic              pf_hit;
   logic [ADDR_W-1:0] pf_data;
   logic [ADDR_W-1:0] pf_adr;

   assign fetch_stall = IRWrite & ~fetch_done;
   assign pf_adr      = PC + ADDR_W'(4);

`ifdef FETCH_PREFETCH_EN
   // PC seen in DONE is the address of the word just loaded; speculate on the next one.
   assign pf_issue = (state_q == S_DONE);

   fetch_prefetch_buf #(
      .ADDR_W(ADDR_W)
   ) u_pf_buf (
      .clk      (clk),
      .reset    (reset),
      .start    (pf_issue),
      .start_adr(pf_adr),
      .pc       (PC),
      .pc_write (PCWrite),
      .pc_next  (pc_next),
      .mem_ready(mem_ready),
      .mem_rdata(mem_rdata),
      .busy     (pf_busy),
      .hit_c    (pf_hit),
      .data     (pf_data)
   );
`else
   assign pf_issue = 1'b0;
   assign pf_busy  = 1'b0;
   assign pf_hit   = 1'b0;
   assign pf_data  = '0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // A demand fetch waits for any speculative read to drain so only one is outstanding.
   always_comb begin
      state_d     = state_q;
      demand_miss = 1'b0;
      buf_hit     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (fetch_stall && !pf_busy) begin
               if (pf_hit) begin
                  buf_hit = 1'b1;
                  state_d = S_DONE;
               end else begin
                  demand_miss = 1'b1;
                  state_d     = S_FETCH;
               end
            end
         end
         S_FETCH: begin
            if (mem_ready) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // mem_adr doubles as the fetch address register; it only moves when a request is issued.
   always_ff @(posedge clk) begin
      if (reset) begin
         PC         <= RESET_PC;
         Instr      <= '0;
         mem_req    <= 1'b0;
         mem_adr    <= '0;
         fetch_done <= 1'b0;
      end else begin
         fetch_done <= (state_d == S_DONE);
         if (PCWrite) begin
            PC <= pc_next;
         end
         if ((state_q == S_FETCH) && mem_ready) begin
            Instr <= mem_rdata;
         end else if (buf_hit) begin
            Instr <= pf_data;
         end
         if (demand_miss) begin
            mem_req <= 1'b1;
            mem_adr <= PC;
         end else if (pf_issue) begin
            mem_req <= 1'b1;
            mem_adr <= pf_adr;
         end else if (mem_ready) begin
            mem_req <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed corner cases plus randomized fetch traffic;
// prefetch scenarios are added when FETCH_PREFETCH_EN is defined.
module tb_fetch_unit;
   import arm_mc_pkg::*;

   localparam int unsigned W       = 32;
   localparam int          TIMEOUT = 60;

   logic         clk = 1'b0;
   logic         reset;
   logic         IRWrite;
   logic         PCWrite;
   logic [W-1:0] pc_next;
   logic         mem_req;
   logic [W-1:0] mem_adr;
   logic         mem_ready;
   logic [W-1:0] mem_rdata;
   logic [W-1:0] Instr;
   logic [W-1:0] PC;
   logic         fetch_stall;
   logic         fetch_done;

   int          n_checks    = 0;
   int          n_pass      = 0;
   int          n_done      = 0;
   int          n_req       = 0;
   int          req_at_done = 0;
   int          next_lat    = 0;
   int          last_lat    = 0;
   bit          rand_lat    = 1'b0;
   bit          auto_mem    = 1'b1;
   logic [31:0] last_req_adr = '0;
   logic [31:0] pc_m         = '0;
   logic [31:0] exp_q [$];
   logic [31:0] mem_init [logic [31:0]];

   always #5 clk = ~clk;

   fetch_unit #(
      .ADDR_W  (W),
      .RESET_PC(32'h0)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .IRWrite    (IRWrite),
      .PCWrite    (PCWrite),
      .pc_next    (pc_next),
      .mem_req    (mem_req),
      .mem_adr    (mem_adr),
      .mem_ready  (mem_ready),
      .mem_rdata  (mem_rdata),
      .Instr      (Instr),
      .PC         (PC),
      .fetch_stall(fetch_stall),
      .fetch_done (fetch_done)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, got, exp);
   endtask

   function automatic logic [31:0] word_at(input logic [31:0] a);
      if (mem_init.exists(a)) return mem_init[a];
      return {a[15:0], a[31:16]} ^ 32'h5A5A_3C3C ^ (a << 3);
   endfunction

   // Memory model: per-request wait states, checks the request is held steady until ready.
   initial begin : responder
      bit          pend;
      int          cnt;
      logic [31:0] adr0;
      pend = 1'b0;
      cnt  = 0;
      adr0 = '0;
      forever begin
         @(posedge clk);
         #1;
         if (!auto_mem) begin
            pend = 1'b0;
         end else if (reset) begin
            pend      = 1'b0;
            mem_ready = 1'b0;
         end else if (mem_ready) begin
            mem_ready = 1'b0;
         end else if (pend || mem_req) begin
            if (!pend) begin
               pend         = 1'b1;
               adr0         = mem_adr;
               last_req_adr = mem_adr;
               n_req++;
               cnt      = rand_lat ? int'($urandom_range(0, 3)) : next_lat;
               last_lat = cnt;
            end else begin
               check("mem_req_hold", {31'b0, mem_req}, 32'd1);
               check("mem_adr_stable", mem_adr, adr0);
            end
            if (cnt == 0) begin
               mem_ready = 1'b1;
               mem_rdata = word_at(adr0);
               pend      = 1'b0;
            end else begin
               cnt--;
            end
         end
      end
   end

   // Scoreboard monitor: every fetch_done must match the oldest outstanding fetch.
   always @(negedge clk) begin
      if (!reset && fetch_done) begin
         logic [31:0] e;
         n_done++;
         if (exp_q.size() == 0) begin
            check("unexpected_fetch_done", {31'b0, fetch_done}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("Instr", Instr, e);
            check("PC_at_done", PC, pc_m);
         end
      end
   end

   task automatic do_reset(input int n);
      @(posedge clk);
      #1;
      reset   = 1'b1;
      IRWrite = 1'b0;
      PCWrite = 1'b0;
      repeat (n) @(posedge clk);
      #1;
      reset = 1'b0;
      pc_m  = '0;
      exp_q.delete();
   endtask

   task automatic set_pc(input logic [31:0] v);
      @(posedge clk);
      #1;
      PCWrite = 1'b1;
      pc_next = v;
      @(posedge clk);
      #1;
      PCWrite = 1'b0;
      pc_m    = v;
   endtask

   // Controller Fetch state: hold IRWrite until fetch_done; optionally write PC+4 then.
   task automatic do_fetch(input bit seq, output int cycles);
      bit got;
      got = 1'b0;
      @(posedge clk);
      #1;
      IRWrite = 1'b1;
      exp_q.push_back(word_at(pc_m));
      cycles = 0;
      while (!got && cycles < TIMEOUT) begin
         @(posedge clk);
         cycles++;
         @(negedge clk);
         if (fetch_done) got = 1'b1;
         else check("fetch_stall_wait", {31'b0, fetch_stall}, 32'd1);
      end
      if (!got) begin
         check("fetch_done_timeout", 32'(cycles), 32'd0);
      end else begin
         req_at_done = n_req;
         check("fetch_stall_done", {31'b0, fetch_stall}, 32'd0);
      end
      IRWrite = 1'b0;
      if (seq) begin
         PCWrite = 1'b1;
         pc_next = pc_m + 32'd4;
      end
      @(posedge clk);
      #1;
      if (seq) begin
         PCWrite = 1'b0;
         pc_m    = pc_m + 32'd4;
      end
   endtask

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks so far", n_pass, n_checks);
      $fatal(1);
   end

   initial begin : main
      int cyc;
      int nreq0;
      int nd0;
      bit seen;
      mem_init[32'h0000_0000] = 32'hE3A0_0005;
      mem_init[32'h0000_0040] = INSTR_NOP;
      mem_init[32'h0000_0080] = 32'hE281_1001;
      reset     = 1'b1;
      IRWrite   = 1'b0;
      PCWrite   = 1'b0;
      pc_next   = '0;
      mem_ready = 1'b0;
      mem_rdata = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst_Instr", Instr, 32'h0);
      check("rst_PC", PC, 32'h0);
      check("rst_mem_req", {31'b0, mem_req}, 32'd0);
      check("rst_fetch_done", {31'b0, fetch_done}, 32'd0);

      // Zero-wait fetch at 0
      next_lat = 0;
      do_fetch(1'b0, cyc);
      check("t1_latency", 32'(cyc), 32'd2);
      @(negedge clk);
      check("t1_Instr", Instr, 32'hE3A0_0005);
      check("t1_PC", PC, 32'h0);

      // Three wait states, single IR load
      do_reset(2);
      set_pc(32'h10);
      next_lat = 3;
      nd0 = n_done;
      do_fetch(1'b0, cyc);
      check("t2_latency", 32'(cyc), 32'd5);
      repeat (3) @(negedge clk);
      check("t2_one_load", 32'(n_done - nd0), 32'd1);
      check("t2_Instr", Instr, word_at(32'h10));

      // PC redirect during an in-flight fetch
      do_reset(2);
      next_lat = 3;
      fork
         do_fetch(1'b0, cyc);
         begin
            repeat (2) @(posedge clk);
            set_pc(32'h40);
         end
      join
      check("t3_latency", 32'(cyc), 32'd5);
      @(negedge clk);
      check("t3_Instr", Instr, word_at(32'h0));
      check("t3_PC", PC, 32'h40);
      do_fetch(1'b0, cyc);
      check("t3_next_adr", last_req_adr, 32'h40);

      // Reset in FETCH with a late ready
      do_reset(2);
      set_pc(32'h20);
      auto_mem = 1'b0;
      @(posedge clk);
      #1 IRWrite = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (mem_req) seen = 1'b1;
      end
      check("t4_req_seen", {31'b0, seen}, 32'd1);
      check("t4_mem_adr", mem_adr, 32'h20);
      @(posedge clk);
      #1;
      reset   = 1'b1;
      IRWrite = 1'b0;
      @(posedge clk);
      #1;
      reset     = 1'b0;
      mem_ready = 1'b1;
      mem_rdata = 32'hDEAD_BEEF;
      pc_m      = '0;
      exp_q.delete();
      @(negedge clk);
      check("t4_mem_req", {31'b0, mem_req}, 32'd0);
      check("t4_Instr", Instr, 32'h0);
      check("t4_PC", PC, 32'h0);
      @(posedge clk);
      #1 mem_ready = 1'b0;
      @(negedge clk);
      check("t4_late_Instr", Instr, 32'h0);
      check("t4_late_done", {31'b0, fetch_done}, 32'd0);
      check("t4_late_req", {31'b0, mem_req}, 32'd0);
      auto_mem = 1'b1;

`ifdef FETCH_PREFETCH_EN
      // Sequential fetch hits the prefetch buffer
      do_reset(2);
      next_lat = 0;
      do_fetch(1'b1, cyc);
      repeat (3) @(posedge clk);
      nreq0 = n_req;
      do_fetch(1'b0, cyc);
      check("t5_hit_latency", 32'(cyc), 32'd1);
      check("t5_no_req", 32'(req_at_done), 32'(nreq0));
      @(negedge clk);
      check("t5_Instr", Instr, word_at(32'h4));

      // Redirect while the prefetch is in flight
      do_reset(2);
      next_lat = 3;
      do_fetch(1'b0, cyc);
      set_pc(32'h80);
      nreq0 = n_req;
      do_fetch(1'b0, cyc);
      check("t6_demand_adr", last_req_adr, 32'h80);
      check("t6_one_req", 32'(req_at_done), 32'(nreq0 + 1));
      @(negedge clk);
      check("t6_Instr", Instr, word_at(32'h80));
`endif

      // Randomized traffic: jumps, sequential PC+4, random wait states
      do_reset(2);
      rand_lat = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 3) == 0) set_pc(32'($urandom_range(0, 255)));
         repeat ($urandom_range(0, 2)) @(posedge clk);
         do_fetch(1'($urandom_range(0, 1)), cyc);
`ifndef FETCH_PREFETCH_EN
         check("rnd_latency", 32'(cyc), 32'(last_lat + 2));
`endif
      end
      repeat (5) @(posedge clk);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
